pipeline_stall_controller: RTL and testbench

- Central hazard/stall/flush sequencer for the 5-stage MIPS32 pipeline.
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register.
- Handles load-use hazards, taken branches/jumps, multi-cycle data-memory waits and multi-cycle mult/div occupancy.
- Keeps a sticky memory-timeout error flag and a stall-cycle counter.

---
 rtl/pipeline_stall_controller.sv | 151 +++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - hazard, stall and flush sequencer for the 5-stage pipeline
// Priority: memory wait > mult/div occupancy > mult/div start > taken branch > load-use > jump.

module pipeline_stall_controller #(
   parameter int unsigned MD_LATENCY  = 4,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        ex_mem_read,
   input  logic        ex_reg_write,
   input  logic [4:0]  ex_write_addr,
   input  logic        ex_branch_taken,
   input  logic        id_jump,
   input  logic        ex_md_start,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_en,
   output logic        idex_flush,
   output logic        exmem_en,
   output logic        exmem_flush,
   output logic        memwb_en,
   output logic        memwb_flush,
   output logic        md_busy,
   output logic        md_done,
   output logic        mem_err,
   output logic [31:0] stall_cycles
);

   typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

   localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 2);
   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_t      state_q, state_d;
   logic [3:0]  md_cnt_q, md_cnt_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        mem_err_q, mem_err_d;
   logic [31:0] stall_q, stall_d;
   logic        mw;
   logic        lu;

   assign mw = mem_req & ~mem_ready;
   assign lu = ex_mem_read & ex_reg_write & (ex_write_addr != 5'd0) &
               ((id_uses_rs & (id_rs == ex_write_addr)) |
                (id_uses_rt & (id_rt == ex_write_addr)));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= RUN;
         md_cnt_q   <= 4'd0;
         wait_cnt_q <= 8'd0;
         mem_err_q  <= 1'b0;
         stall_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         md_cnt_q   <= md_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
         stall_q    <= stall_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      md_cnt_d    = md_cnt_q;
      wait_cnt_d  = 8'd0;
      mem_err_d   = mem_err_q;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_en     = 1'b1;
      idex_flush  = 1'b0;
      exmem_en    = 1'b1;
      exmem_flush = 1'b0;
      memwb_en    = 1'b1;
      memwb_flush = 1'b0;
      md_busy     = (state_q == MD_BUSY);
      md_done     = 1'b0;

      if (mw) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_flush = 1'b1;
         wait_cnt_d  = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
         if (wait_cnt_d >= TIMEOUT) begin
            mem_err_d = 1'b1;
         end
         // The multiplier keeps running while memory stalls; only the exit waits.
         if ((state_q == MD_BUSY) && (md_cnt_q != 4'd0)) begin
            md_cnt_d = md_cnt_q - 4'd1;
         end
      end else if (state_q == MD_BUSY) begin
         pc_en   = 1'b0;
         ifid_en = 1'b0;
         idex_en = 1'b0;
         if (md_cnt_q != 4'd0) begin
            exmem_flush = 1'b1;
            md_cnt_d    = md_cnt_q - 4'd1;
         end else begin
            md_done = 1'b1;
            state_d = RUN;
         end
      end else if (ex_md_start) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_flush = 1'b1;
         md_cnt_d    = MD_INIT;
         state_d     = MD_BUSY;
      end else if (ex_branch_taken) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (lu) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (id_jump) begin
         ifid_flush = 1'b1;
      end

      stall_d = stall_q + {31'd0, ~pc_en};

      if (!reset) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_en     = 1'b0;
         idex_flush  = 1'b1;
         exmem_en    = 1'b0;
         exmem_flush = 1'b1;
         memwb_en    = 1'b0;
         memwb_flush = 1'b1;
         md_busy     = 1'b0;
         md_done     = 1'b0;
      end
   end

   assign mem_err      = mem_err_q;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - self-checking bench for pipeline_stall_controller
// Output vector order: {pc,ifid_en,ifid_fl,idex_en,idex_fl,exmem_en,exmem_fl,memwb_en,memwb_fl,busy,done}.

module tb_pipeline_stall_controller;

   localparam int MD_LAT = 4;

   typedef struct {
      logic [4:0] rs, rt;
      logic       urs, urt, mr, rw;
      logic [4:0] wa;
      logic       br, jmp, mds, mreq, mrdy;
   } in_t;

   typedef struct {
      in_t         in;
      logic [10:0] exp;
   } vec_t;

   localparam logic [10:0] DEF = 11'b11010101000;
   localparam logic [10:0] LU  = 11'b00011101000;
   localparam logic [10:0] BR  = 11'b11111101000;
   localparam logic [10:0] JMP = 11'b11110101000;
   localparam logic [10:0] MW  = 11'b00000001100;
   localparam logic [10:0] RST = 11'b00101010100;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  id_rs = '0, id_rt = '0, ex_write_addr = '0;
   logic        id_uses_rs = 0, id_uses_rt = 0, ex_mem_read = 0, ex_reg_write = 0;
   logic        ex_branch_taken = 0, id_jump = 0, ex_md_start = 0, mem_req = 0, mem_ready = 0;
   logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush;
   logic        memwb_en, memwb_flush, md_busy, md_done, mem_err;
   logic [31:0] stall_cycles;
   logic        t_pc_en, t_ifid_en, t_ifid_flush, t_idex_en, t_idex_flush, t_exmem_en, t_exmem_flush;
   logic        t_memwb_en, t_memwb_flush, t_md_busy, t_md_done, t_mem_err;
   logic [31:0] t_stall_cycles;
   logic [10:0] act;

   always #5 clock = ~clock;

   pipeline_stall_controller #(.MD_LATENCY(MD_LAT), .MEM_TIMEOUT(255)) dut (
      .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
      .ex_reg_write(ex_reg_write), .ex_write_addr(ex_write_addr),
      .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .ex_md_start(ex_md_start),
      .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
      .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
      .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en),
      .memwb_flush(memwb_flush), .md_busy(md_busy), .md_done(md_done),
      .mem_err(mem_err), .stall_cycles(stall_cycles));

   pipeline_stall_controller #(.MD_LATENCY(MD_LAT), .MEM_TIMEOUT(2)) dut_t (
      .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
      .ex_reg_write(ex_reg_write), .ex_write_addr(ex_write_addr),
      .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .ex_md_start(ex_md_start),
      .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(t_pc_en), .ifid_en(t_ifid_en),
      .ifid_flush(t_ifid_flush), .idex_en(t_idex_en), .idex_flush(t_idex_flush),
      .exmem_en(t_exmem_en), .exmem_flush(t_exmem_flush), .memwb_en(t_memwb_en),
      .memwb_flush(t_memwb_flush), .md_busy(t_md_busy), .md_done(t_md_done),
      .mem_err(t_mem_err), .stall_cycles(t_stall_cycles));

   assign act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
                 memwb_en, memwb_flush, md_busy, md_done};

   int          checks = 0;
   int          passed = 0;
   vec_t        tab[$];
   logic [10:0] last_act;

   // Reference model: mult/div occupancy as "cycles left including the done cycle".
   bit          m_busy;
   int          m_left;
   int          m_wait;
   bit          m_err, m_err2;
   logic [31:0] m_stalls;

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
      else passed++;
   endtask

   function automatic logic [10:0] care(input logic [10:0] e);
      logic [10:0] c;
      c = '1;
      if (!e[9]) c[8] = 1'b0;
      if (!e[7]) c[6] = 1'b0;
      if (!e[5]) c[4] = 1'b0;
      if (!e[3]) c[2] = 1'b0;
      return c;
   endfunction

   task automatic chk_out(input string name, input logic [10:0] a, input logic [10:0] e);
      logic [10:0] c;
      c = care(e);
      chk(name, {21'd0, a & c}, {21'd0, e & c});
   endtask

   function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                              input logic urt, input logic mr, input logic rw,
                              input logic [4:0] wa, input logic br, input logic jmp,
                              input logic mds, input logic mreq, input logic mrdy);
      in_t v;
      v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mr = mr; v.rw = rw;
      v.wa = wa; v.br = br; v.jmp = jmp; v.mds = mds; v.mreq = mreq; v.mrdy = mrdy;
      return v;
   endfunction

   task automatic add(input in_t v, input logic [10:0] e);
      vec_t r;
      r.in = v; r.exp = e;
      tab.push_back(r);
   endtask

   task automatic apply(input in_t v);
      id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
      ex_mem_read = v.mr; ex_reg_write = v.rw; ex_write_addr = v.wa;
      ex_branch_taken = v.br; id_jump = v.jmp; ex_md_start = v.mds;
      mem_req = v.mreq; mem_ready = v.mrdy;
   endtask

   task automatic model_reset();
      m_busy = 0; m_left = 0; m_wait = 0; m_err = 0; m_err2 = 0; m_stalls = 0;
   endtask

   task automatic model_eval(input in_t v, output logic [10:0] e);
      bit mw, lu;
      mw = v.mreq && !v.mrdy;
      lu = v.mr && v.rw && v.wa != 0 &&
           ((v.urs && v.rs == v.wa) || (v.urt && v.rt == v.wa));
      e = DEF;
      if (mw) e = MW;
      else if (m_busy) begin
         e[10] = 0; e[9] = 0; e[7] = 0;
         if (m_left > 1) e[4] = 1; else e[0] = 1;
      end else if (v.mds) begin
         e[10] = 0; e[9] = 0; e[7] = 0; e[4] = 1;
      end else if (v.br) e = BR;
      else if (lu) e = LU;
      else if (v.jmp) e = JMP;
      e[1] = m_busy;
   endtask

   task automatic model_commit(input in_t v, input logic [10:0] e);
      if (v.mreq && !v.mrdy) begin
         if (m_wait < 255) m_wait++;
         if (m_wait >= 255) m_err = 1;
         if (m_wait >= 2) m_err2 = 1;
         if (m_busy && m_left > 1) m_left--;
      end else begin
         m_wait = 0;
         if (m_busy) begin
            if (m_left == 1) m_busy = 0;
            else m_left--;
         end else if (v.mds) begin
            m_busy = 1;
            m_left = MD_LAT - 1;
         end
      end
      if (!e[10]) m_stalls = m_stalls + 32'd1;
   endtask

   // Starts and ends at a falling edge; samples 1 time unit after applying inputs.
   task automatic step(input in_t v, input bit use_tab, input logic [10:0] tab_e);
      logic [10:0] e;
      apply(v);
      #1;
      model_eval(v, e);
      last_act = act;
      chk_out("outputs_vs_model", act, e);
      if (use_tab) chk_out("outputs_vs_table", act, tab_e);
      chk("stall_cycles", stall_cycles, m_stalls);
      chk("mem_err", {31'd0, mem_err}, {31'd0, m_err});
      chk("mem_err_timeout2", {31'd0, t_mem_err}, {31'd0, m_err2});
      @(posedge clock);
      model_commit(v, e);
      @(negedge clock);
   endtask

   initial begin
      in_t idle, v;
      logic [31:0] s0;
      logic exp_fl[5];
      logic exp_dn[5];

      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(mk(5, 0, 1, 0, 1, 1, 5, 0, 0, 0, 0, 0), LU);
      add(mk(0, 7, 0, 1, 1, 1, 7, 0, 0, 0, 0, 0), LU);
      add(mk(0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0), DEF);
      add(mk(5, 0, 1, 0, 1, 0, 5, 0, 0, 0, 0, 0), DEF);
      add(mk(5, 0, 1, 0, 0, 1, 5, 0, 0, 0, 0, 0), DEF);
      add(mk(5, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0), DEF);
      add(mk(5, 0, 1, 0, 1, 1, 6, 0, 0, 0, 0, 0), DEF);
      add(mk(5, 0, 1, 0, 1, 1, 5, 1, 0, 0, 0, 0), BR);
      add(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), JMP);
      add(mk(3, 0, 1, 0, 1, 1, 3, 0, 1, 0, 0, 0), LU);
      add(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), BR);
      add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0), MW);
      add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), DEF);
      add(mk(31, 31, 1, 1, 1, 1, 31, 0, 0, 0, 0, 0), LU);

      apply(idle);
      repeat (2) @(negedge clock);
      #1;
      chk("reset_outputs", {21'd0, act}, {21'd0, RST});
      chk("reset_stall", stall_cycles, 32'd0);
      chk("reset_mem_err", {31'd0, mem_err}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      model_reset();

      // load-use: one bubble, then defaults
      step(mk(5, 0, 1, 0, 1, 1, 5, 0, 0, 0, 0, 0), 1, LU);
      step(idle, 1, DEF);
      chk("lu_stall_count", stall_cycles, 32'd1);
      step(mk(5, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0), 1, DEF);

      foreach (tab[i]) step(tab[i].in, 1, tab[i].exp);

      // mult/div occupancy, cycle 0 is the start cycle
      exp_fl = '{1, 1, 1, 0, 0};
      exp_dn = '{0, 0, 0, 1, 0};
      s0 = stall_cycles;
      for (int i = 0; i < 5; i++) begin
         v = idle;
         v.mds = (i == 0);
         step(v, 0, DEF);
         chk($sformatf("md_exmem_flush_c%0d", i), {31'd0, last_act[4]}, {31'd0, exp_fl[i]});
         chk($sformatf("md_done_c%0d", i), {31'd0, last_act[0]}, {31'd0, exp_dn[i]});
         if (i > 0) chk($sformatf("md_busy_c%0d", i), {31'd0, last_act[1]}, {31'd0, (i < 4)});
      end
      chk("md_stall_count", stall_cycles, s0 + 32'd4);

      // memory wait of 3 cycles then ready
      chk("timeout_clear_before", {31'd0, t_mem_err}, 32'd0);
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(v, 1, MW);
      end
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1, DEF);
      chk("mw_no_err_default", {31'd0, mem_err}, 32'd0);
      chk("mw_err_timeout2", {31'd0, t_mem_err}, 32'd1);
      repeat (3) step(idle, 1, DEF);
      chk("mw_err_sticky", {31'd0, t_mem_err}, 32'd1);

      // memory wait landing inside MD_BUSY at md_cnt==1
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0, DEF);
      step(idle, 0, DEF);
      for (int i = 0; i < 2; i++) begin
         step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0, DEF);
         chk("mdmw_done_held", {31'd0, last_act[0]}, 32'd0);
         chk("mdmw_busy_held", {31'd0, last_act[1]}, 32'd1);
      end
      step(idle, 0, DEF);
      chk("mdmw_done", {31'd0, last_act[0]}, 32'd1);
      step(idle, 0, DEF);
      chk("mdmw_back_run", {31'd0, last_act[1]}, 32'd0);

      for (int n = 0; n < 500; n++) begin
         v.rs   = 5'($urandom_range(0, 3));
         v.rt   = 5'($urandom_range(0, 3));
         v.wa   = 5'($urandom_range(0, 3));
         v.urs  = 1'($urandom);
         v.urt  = 1'($urandom);
         v.mr   = 1'($urandom);
         v.rw   = 1'($urandom);
         v.br   = ($urandom_range(0, 7) == 0);
         v.jmp  = ($urandom_range(0, 5) == 0);
         v.mds  = ($urandom_range(0, 9) == 0);
         v.mreq = ($urandom_range(0, 2) == 0);
         v.mrdy = ($urandom_range(0, 2) != 0);
         step(v, 0, DEF);
      end

      // asynchronous reset in the middle of MD_BUSY
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 0, DEF);
      step(idle, 0, DEF);
      #3;
      reset = 1'b0;
      #1;
      chk("async_rst_outputs", {21'd0, act}, {21'd0, RST});
      chk("async_rst_stall", stall_cycles, 32'd0);
      chk("async_rst_err", {31'd0, t_mem_err}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      model_reset();
      step(idle, 1, DEF);
      chk("post_rst_busy", {31'd0, last_act[1]}, 32'd0);
      step(idle, 1, DEF);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
